// File: rtl/can_rs_pulse_decoder.sv
// Register-select one-pulse generator: turns each host CS access into a single
// one-hot read or write strobe of PULSE_LEN cycles. Optional o_addr_err via CAN_RSDEC_ADDR_ERR_EN.
module can_rs_pulse_decoder #(
    parameter int NUM_REGS  = 31,
    parameter int ADDR_W    = 5,
    parameter int PULSE_LEN = 1
) (
    input  logic                i_sys_clk,
    input  logic                i_reset_n,
    input  logic                i_cs,
    input  logic                i_r_neg_w,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_rd_vector,
    output logic [NUM_REGS-1:0] o_wr_vector,
    output logic [NUM_REGS-1:0] o_rs_vector,
    output logic                o_busy
`ifdef CAN_RSDEC_ADDR_ERR_EN
    ,
    output logic                o_addr_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(PULSE_LEN - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                dir_q, dir_d;
    logic [NUM_REGS-1:0] rd_q, rd_d;
    logic [NUM_REGS-1:0] wr_q, wr_d;
    logic [NUM_REGS-1:0] rs_q, rs_d;
    logic                busy_q, busy_d;
    logic [NUM_REGS-1:0] onehot;
    logic                pulse_now;
`ifdef CAN_RSDEC_ADDR_ERR_EN
    logic                err_q, err_d;
    logic                in_range;
`endif

    // Out-of-range addresses simply match no bit, so the vectors stay zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = (32'(addr_q) == i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dir_d   = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (i_cs) begin
                    addr_d  = i_addr;
                    dir_d   = i_r_neg_w;
                    cnt_d   = CNT_INIT;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (!i_cs) begin
                    state_d = ST_IDLE;
                end else if (i_r_neg_w != dir_q) begin
                    // Direction flip under a held CS is a fresh access.
                    addr_d  = i_addr;
                    dir_d   = i_r_neg_w;
                    cnt_d   = CNT_INIT;
                    state_d = ST_PULSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Strobes are registered from the current state, so they trail PULSE by one edge.
    always_comb begin
        pulse_now = (state_q == ST_PULSE);
        rd_d      = (pulse_now && dir_q)  ? onehot : '0;
        wr_d      = (pulse_now && !dir_q) ? onehot : '0;
        rs_d      = rd_d | wr_d;
        busy_d    = pulse_now;
`ifdef CAN_RSDEC_ADDR_ERR_EN
        in_range  = (32'(addr_q) < 32'(NUM_REGS));
        err_d     = pulse_now && !in_range;
`endif
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            rs_q    <= '0;
            busy_q  <= 1'b0;
`ifdef CAN_RSDEC_ADDR_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
`ifdef CAN_RSDEC_ADDR_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_rd_vector = rd_q;
    assign o_wr_vector = wr_q;
    assign o_rs_vector = rs_q;
    assign o_busy      = busy_q;
`ifdef CAN_RSDEC_ADDR_ERR_EN
    assign o_addr_err  = err_q;
`endif

endmodule

// File: tb/tb_can_rs_pulse_decoder.sv
// Bench for can_rs_pulse_decoder: three parameterisations share one stimulus stream and
// are checked every cycle against an access-timeline reference model.
module tb_can_rs_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       dir;
    logic [4:0] addr;

    always #5 clk = ~clk;

    logic [30:0] a_rd, a_wr, a_rs;
    logic [30:0] b_rd, b_wr, b_rs;
    logic [19:0] c_rd, c_wr, c_rs;
    logic [30:0] c_rd_x, c_wr_x, c_rs_x;
    logic        a_busy, b_busy, c_busy;
    logic        a_err, b_err, c_err;

    assign c_rd_x = {11'b0, c_rd};
    assign c_wr_x = {11'b0, c_wr};
    assign c_rs_x = {11'b0, c_rs};

    can_rs_pulse_decoder #(.NUM_REGS(31), .ADDR_W(5), .PULSE_LEN(1)) u_a (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_r_neg_w(dir), .i_addr(addr),
        .o_rd_vector(a_rd), .o_wr_vector(a_wr), .o_rs_vector(a_rs), .o_busy(a_busy)
`ifdef CAN_RSDEC_ADDR_ERR_EN
        , .o_addr_err(a_err)
`endif
    );

    can_rs_pulse_decoder #(.NUM_REGS(31), .ADDR_W(5), .PULSE_LEN(3)) u_b (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_r_neg_w(dir), .i_addr(addr),
        .o_rd_vector(b_rd), .o_wr_vector(b_wr), .o_rs_vector(b_rs), .o_busy(b_busy)
`ifdef CAN_RSDEC_ADDR_ERR_EN
        , .o_addr_err(b_err)
`endif
    );

    can_rs_pulse_decoder #(.NUM_REGS(20), .ADDR_W(5), .PULSE_LEN(4)) u_c (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_cs(cs), .i_r_neg_w(dir), .i_addr(addr),
        .o_rd_vector(c_rd), .o_wr_vector(c_wr), .o_rs_vector(c_rs), .o_busy(c_busy)
`ifdef CAN_RSDEC_ADDR_ERR_EN
        , .o_addr_err(c_err)
`endif
    );

`ifndef CAN_RSDEC_ADDR_ERR_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
    assign c_err = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: each instance remembers the edge at which its current access was
    // sampled; strobes are expected on the PULSE_LEN edges that follow it.
    int          m_len [3] = '{1, 3, 4};
    int          m_nr  [3] = '{31, 31, 20};
    bit          m_act [3];
    bit          m_rel [3];
    bit          m_dir [3];
    int          m_addr[3];
    int          m_n   [3];
    logic [30:0] e_rd  [3];
    logic [30:0] e_wr  [3];
    logic        e_busy[3];
    logic        e_err [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i]  = 1'b0;
            m_rel[i]  = 1'b0;
            e_rd[i]   = '0;
            e_wr[i]   = '0;
            e_busy[i] = 1'b0;
            e_err[i]  = 1'b0;
        end
    endtask

    task automatic model_edge(input int e, input logic c, input logic d, input int a);
        for (int i = 0; i < 3; i++) begin
            bit          on;
            logic [30:0] vec;
            on  = m_act[i] && (e >= m_n[i] + 1) && (e <= m_n[i] + m_len[i]);
            vec = (m_addr[i] < m_nr[i]) ? (31'd1 << m_addr[i]) : 31'd0;
            e_rd[i]   = (on && m_dir[i])  ? vec : 31'd0;
            e_wr[i]   = (on && !m_dir[i]) ? vec : 31'd0;
            e_busy[i] = on;
            e_err[i]  = on && (m_addr[i] >= m_nr[i]);
            if (m_act[i] && e <= m_n[i] + m_len[i]) begin
                // strobe still running: inputs ignored
            end else if (m_act[i] && !m_rel[i]) begin
                if (!c) begin
                    m_rel[i] = 1'b1;
                end else if (d != m_dir[i]) begin
                    m_n[i] = e; m_dir[i] = d; m_addr[i] = a;
                end
            end else if (c) begin
                m_act[i] = 1'b1; m_rel[i] = 1'b0;
                m_n[i] = e; m_dir[i] = d; m_addr[i] = a;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [30:0] obs, input logic [30:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic check_inst(input string nm, input int i, input logic [30:0] rd,
                              input logic [30:0] wr, input logic [30:0] rs,
                              input logic busy, input logic err);
        chk({nm, "_rd"}, rd, e_rd[i]);
        chk({nm, "_wr"}, wr, e_wr[i]);
        chk({nm, "_rs"}, rs, e_rd[i] | e_wr[i]);
        chk({nm, "_busy"}, 31'(busy), 31'(e_busy[i]));
`ifdef CAN_RSDEC_ADDR_ERR_EN
        chk({nm, "_err"}, 31'(err), 31'(e_err[i]));
`else
        if (err !== 1'b0) chk({nm, "_err_tie"}, 31'(err), 31'd0);
`endif
    endtask

    task automatic check_all();
        check_inst("a", 0, a_rd, a_wr, a_rs, a_busy, a_err);
        check_inst("b", 1, b_rd, b_wr, b_rs, b_busy, b_err);
        check_inst("c", 2, c_rd_x, c_wr_x, c_rs_x, c_busy, c_err);
    endtask

    task automatic step(input logic c, input logic d, input int a);
        cs   = c;
        dir  = d;
        addr = 5'(a);
        @(posedge clk);
        cyc++;
        model_edge(cyc, c, d, a);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0);
    endtask

    // Asynchronous reset asserted away from the edge; outputs must clear at once.
    task automatic async_reset(input int edges);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int k = 0; k < edges; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cs    = 1'b0;
        dir   = 1'b0;
        addr  = 5'd0;
        model_reset();
        #1;
        check_all();
        async_reset(2);

        // Read of register 5 with CS held: one strobe only.
        idle(2);
        step(1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 5);
        chk("t1_a_rd_0x20", a_rd, 31'h20);
        step(1'b1, 1'b1, 5);
        chk("t1_a_rd_done", a_rd, 31'h0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 5);
        idle(6);

        // Write of register 30: three-cycle strobe on the PULSE_LEN=3 instance.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 30);
            chk("t2_b_wr30", b_wr, (k >= 1 && k <= 3) ? 31'h4000_0000 : 31'h0);
        end
        idle(3);

        // Held CS: read of 2, address change without direction change, then write of 7.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 2);
        for (int k = 0; k < 2; k++) step(1'b1, 1'b1, 9);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 7);
        idle(6);

        // Address 25: in range for NUM_REGS=31, out of range for NUM_REGS=20.
        step(1'b1, 1'b0, 25);
        idle(6);

        // Reset during the second strobe cycle, released with CS still high.
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 3);
        async_reset(1);
        chk("t5_c_busy_rst", 31'(c_busy), 31'd0);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 3);
        chk("t5_c_rd_fresh", c_rd_x, 31'h8);
        idle(6);

        // Randomised traffic with occasional asynchronous resets.
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset(int'($urandom_range(0, 2)));
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 31)));
            end
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/can_rs_pulse_decoder.md
# can_rs_pulse_decoder

- Parametrised register-select one-pulse generator for the CAN controller Microcontroller Interface.
- Converts each host chip-select access (binary register address plus read/write direction) into a registered one-hot read or write strobe of programmable length, issued exactly once per access.
- Replaces the fixed 31-register decoder path: the address decode is internal, and read and write strobes are separate vectors.
- Sits between the host bus synchroniser and the CAN register file.

## Interface
Parameters:
- NUM_REGS, default 31: number of addressable registers, which is also the width of the strobe vectors; legal range 2..256.
- ADDR_W, default 5: width of i_addr; must satisfy 2**ADDR_W >= NUM_REGS.
- PULSE_LEN, default 1: strobe length in i_sys_clk cycles; legal range 1..15.

Ports:
- i_sys_clk  in  1  system clock; one clock domain only.
- i_reset_n  in  1  asynchronous active-low reset.
- i_cs  in  1  host chip select, already synchronous to i_sys_clk.
- i_r_neg_w  in  1  1 = read, 0 = write; sampled together with i_cs.
- i_addr  in  ADDR_W  binary register index.
- o_rd_vector  out  NUM_REGS  one-hot read strobe.
- o_wr_vector  out  NUM_REGS  one-hot write strobe.
- o_rs_vector  out  NUM_REGS  o_rd_vector OR o_wr_vector.
- o_busy  out  1  high while a strobe is active.
- o_addr_err  out  1  out-of-range access strobe; present only with CAN_RSDEC_ADDR_ERR_EN.

## Operation
- FSM states: IDLE, PULSE, HOLD.
- IDLE: when i_cs=1 is sampled, capture i_addr and i_r_neg_w into internal registers, load the length counter with PULSE_LEN-1, and go to PULSE. Otherwise stay in IDLE.
- PULSE:
  - Drive bit [captured addr] of o_rd_vector (if read) or o_wr_vector (if write); all other bits are 0.
  - o_busy=1.
  - Decrement the counter each cycle. At counter 0, go to HOLD.
  - i_cs and i_r_neg_w are ignored in PULSE.
- HOLD:
  - All strobes are 0.
  - i_cs=0: go to IDLE.
  - i_cs=1 with i_r_neg_w different from the captured direction: treat as a new access. Recapture address and direction, and return to PULSE. This is a back-to-back read-to-write or write-to-read access without releasing CS.
  - i_cs=1 with the same direction: stay in HOLD. No repeat pulse, even if i_addr changes.
- Out-of-range access (captured addr >= NUM_REGS):
  - The FSM sequence is unchanged, including PULSE duration and o_busy.
  - No vector bit is set.
- Illegal or unused state encodings return to IDLE on the next clock.
- The rd and wr vectors are never non-zero in the same cycle. At most one bit of o_rs_vector is set at any time.

## Timing
- All outputs are registered.
- Reset values: o_rd_vector, o_wr_vector and o_rs_vector are all 0; o_busy=0; o_addr_err=0; state is IDLE; counter is 0.
- Reset clears outputs immediately on assertion, including mid-pulse; it is released synchronously to the next edge.
- Latency: i_cs is sampled high at edge N. The strobe is visible after edge N+1 and stays high for exactly PULSE_LEN cycles.
- Minimum spacing between two accesses separated by a CS release: PULSE_LEN+2 cycles (PULSE, HOLD, IDLE).
- Back-to-back direction change: a new strobe starts one cycle after the direction change is sampled in HOLD.
- After reset deassertion with i_cs already high: this counts as a new access, and a strobe is issued.

## Configuration
- Macro: CAN_RSDEC_ADDR_ERR_EN.
- Defined:
  - The o_addr_err port exists.
  - It is high for the same PULSE_LEN cycles as a strobe would be, whenever the captured address is >= NUM_REGS.
  - It is 0 otherwise.
- Undefined:
  - The port and its logic are removed.
  - Out-of-range accesses complete silently with all vectors at 0.

## Test plan
- Defaults. Reset, then i_cs=1 with i_r_neg_w=1 and i_addr=5, held for 6 cycles. Expect o_rd_vector=0x20 for exactly 1 cycle, two cycles after CS rises; o_wr_vector stays 0; no second pulse while CS is held.
- PULSE_LEN=3, write to i_addr=30. Expect o_wr_vector bit 30 and o_busy high for exactly 3 cycles, then 0. Release CS; the FSM returns to IDLE one cycle later.
- CS held at 1. Read at addr 2, then i_r_neg_w goes to 0 in HOLD with addr 7. Expect an rd pulse on bit 2, then a wr pulse on bit 7. Changing addr without changing direction gives no pulse.
- NUM_REGS=20, ADDR_W=5, write to addr 25. With the macro: o_addr_err=1 for PULSE_LEN cycles and all vectors 0. Without the macro: all vectors 0 and no error output.
- PULSE_LEN=4. Assert i_reset_n=0 during the second pulse cycle. All outputs are 0 immediately. After release with i_cs=1, a fresh strobe appears after two clock edges.
